// File: rtl/pulse_generator_regbank_if.sv
// Byte-wide register bus shared by the pulse generator configuration banks.
interface pulse_generator_regbank_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  i_wr;
   logic                  i_rd;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [DATA_WIDTH-1:0] i_data;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_data_valid;
   logic                  o_wr_err;

   modport master (
      output i_wr, i_rd, i_addr, i_data,
      input  o_data, o_data_valid, o_wr_err
   );

   modport slave (
      input  i_wr, i_rd, i_addr, i_data,
      output o_data, o_data_valid, o_wr_err
   );
endinterface

// File: rtl/pulse_generator_regbank.sv
// Multi-channel pulse generator register bank: bus-writable shadow registers,
// atomic shadow-to-active commit at the channel's period boundary.
module pulse_generator_regbank #(
   parameter int unsigned          N_CH       = 4,
   parameter int unsigned          ADDR_WIDTH = 8,
   parameter int unsigned          DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h40
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   pulse_generator_regbank_if.slave         bus,
   input  logic [N_CH-1:0]                  i_ch_idle,
   output logic [N_CH*14*DATA_WIDTH-1:0]    o_cfg,
   output logic [N_CH-1:0]                  o_commit_done
);
   localparam int unsigned N_REG = 14;
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned SPAN  = 16 * N_CH;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t                r_state    [N_CH];
   state_t                w_state_nxt[N_CH];
   logic [DATA_WIDTH-1:0] r_shadow   [N_CH][N_REG];
   logic [DATA_WIDTH-1:0] r_active   [N_CH][N_REG];
   logic [N_CH-1:0]       r_lock;
   logic [N_CH-1:0]       r_done;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_wr_err;

   logic [ADDR_WIDTH-1:0] w_off;
   logic                  w_in_range;
   logic [CH_W-1:0]       w_ch;
   logic [3:0]            w_k;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_ctrl_wr;
   logic                  w_reg_wr;
   logic                  w_wr_err;
   logic                  w_lock_sel;
   logic                  w_pend_sel;
   logic [DATA_WIDTH-1:0] w_shadow_sel;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [N_CH-1:0]       w_req;
   logic [N_CH-1:0]       w_copy;

   assign w_off      = bus.i_addr - BASE_ADDR;
   assign w_in_range = (32'(w_off) < SPAN);
   assign w_ch       = w_off[4 +: CH_W];
   assign w_k        = w_off[3:0];
   assign w_wr       = bus.i_wr;
   assign w_rd       = bus.i_rd & ~bus.i_wr;
   assign w_ctrl_wr  = w_wr & w_in_range & (w_k == 4'd14);
   assign w_reg_wr   = w_wr & w_in_range & (w_k < 4'd14);

   // Address decode: per-channel lock/pending/shadow selected by the bus address.
   always_comb begin
      w_lock_sel   = 1'b0;
      w_pend_sel   = 1'b0;
      w_shadow_sel = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
         if (w_ch == CH_W'(c)) begin
            w_lock_sel = r_lock[c];
            w_pend_sel = (r_state[c] == ST_WAIT);
            for (int k = 0; k < int'(N_REG); k++) begin
               if (w_k == 4'(k)) w_shadow_sel = r_shadow[c][k];
            end
         end
      end
      w_wr_err  = w_wr & (~w_in_range | (w_k == 4'd15) | (w_reg_wr & w_lock_sel));
      w_rd_data = '0;
      if (w_in_range) begin
         if (w_k == 4'd15)      w_rd_data = DATA_WIDTH'({w_lock_sel, w_pend_sel});
         else if (w_k == 4'd14) w_rd_data = DATA_WIDTH'({w_lock_sel, 1'b0});
         else                   w_rd_data = w_shadow_sel;
      end
   end

   // Commit FSM next state; copy happens on the WAIT->DONE transition.
   always_comb begin
      w_req  = '0;
      w_copy = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
         w_state_nxt[c] = r_state[c];
         w_req[c]       = w_ctrl_wr & (w_ch == CH_W'(c)) & bus.i_data[0];
         case (r_state[c])
            ST_IDLE: if (w_req[c]) w_state_nxt[c] = ST_WAIT;
            ST_WAIT: begin
               if (i_ch_idle[c]) begin
                  w_copy[c]      = 1'b1;
                  w_state_nxt[c] = ST_DONE;
               end
            end
            ST_DONE: w_state_nxt[c] = w_req[c] ? ST_WAIT : ST_IDLE;
            default: w_state_nxt[c] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int c = 0; c < int'(N_CH); c++) r_state[c] <= ST_IDLE;
         r_done <= '0;
      end else begin
         for (int c = 0; c < int'(N_CH); c++) begin
            r_state[c] <= w_state_nxt[c];
            r_done[c]  <= (w_state_nxt[c] == ST_DONE);
         end
      end
   end

   // Register storage; shadow writes and the copy both use pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int c = 0; c < int'(N_CH); c++) begin
            for (int k = 0; k < int'(N_REG); k++) begin
               r_shadow[c][k] <= '0;
               r_active[c][k] <= '0;
            end
         end
         r_lock   <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_wr_err <= 1'b0;
      end else begin
         for (int c = 0; c < int'(N_CH); c++) begin
            if (w_ctrl_wr && (w_ch == CH_W'(c))) r_lock[c] <= bus.i_data[1];
            for (int k = 0; k < int'(N_REG); k++) begin
               if (w_copy[c]) r_active[c][k] <= r_shadow[c][k];
               if (w_reg_wr && !w_lock_sel && (w_ch == CH_W'(c)) && (w_k == 4'(k)))
                  r_shadow[c][k] <= bus.i_data;
            end
         end
         r_wr_err <= w_wr_err;
         r_valid  <= w_rd;
         r_data   <= w_rd ? w_rd_data : '0;
      end
   end

   always_comb begin
      o_cfg = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
         for (int k = 0; k < int'(N_REG); k++) begin
            o_cfg[(c*int'(N_REG)+k)*int'(DATA_WIDTH) +: DATA_WIDTH] = r_active[c][k];
         end
      end
   end

   assign o_commit_done    = r_done;
   assign bus.o_data       = r_data;
   assign bus.o_data_valid = r_valid;
   assign bus.o_wr_err     = r_wr_err;
endmodule
